// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: one write burst and one read burst in flight, byte-strobed RAM.
// Latency: write response one cycle after the final W beat; first read beat one cycle after AR.
// Backpressure: AW/AR stall while busy; B and R outputs hold until bready/rready.
module axi_mem_slave #(
  parameter int AW             = 32,
  parameter int DW             = 64,
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic                axi_aclk,
  input  logic                rst,
  // write address channel
  input  logic [AW-1:0]       axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  // write data channel
  input  logic [DW-1:0]       axi_wdata,
  input  logic [DW/8-1:0]     axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  // write response channel
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  // read address channel
  input  logic [AW-1:0]       axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  // read data channel
  output logic [DW-1:0]       axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int NB    = DW / 8;
  localparam int LNB   = $clog2(NB);
  localparam int IW    = MEM_WORDS_LOG2;
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Address of the beat that follows 'addr' within a burst.
  // Reserved burst type advances like INCR; WRAP wraps inside a (len+1)<<size window.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [7:0]    len,
                                              input logic [2:0]    size,
                                              input logic [1:0]    burst);
    logic [AW-1:0] step;
    logic [AW-1:0] bound;
    logic [AW-1:0] mask;
    logic [AW-1:0] nxt;
    step  = AW'(1) << size;
    bound = AW'({1'b0, len} + 9'd1) << size;
    mask  = bound - AW'(1);
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~mask) | ((addr + step) & mask);
      default: nxt = addr + step;
    endcase
    return nxt;
  endfunction

  // Burst-level errors: reserved type, illegal WRAP length, or a beat wider than the bus.
  function automatic logic burst_err(input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
    logic e;
    e = (burst == 2'b11) || (size > 3'(LNB));
    if (burst == 2'b10 &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      e = 1'b1;
    return e;
  endfunction

  // True when the byte address falls inside the RAM.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> (IW + LNB)) == '0;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  wstate_t       w_state;
  wstate_t       w_state_nxt;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len;
  logic [2:0]    w_size;
  logic [1:0]    w_burst;
  logic [7:0]    w_cnt;      // beats remaining after the current one
  logic          w_err;      // burst already known to be SLVERR
  logic [1:0]    b_resp;

  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          w_final;
  logic          w_last_bad;
  logic          w_beat_dec;
  logic          w_beat_slv;
  logic [1:0]    w_beat_resp;
  logic          w_do_write;
  logic [IW-1:0] w_idx;

  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign b_hs        = axi_bvalid & axi_bready;
  assign w_final     = (w_cnt == 8'd0);
  assign w_last_bad  = (axi_wlast != w_final);
  assign w_beat_dec  = !in_range(w_addr);
  assign w_beat_slv  = w_err | w_last_bad;
  assign w_beat_resp = w_beat_dec ? RESP_DECERR : (w_beat_slv ? RESP_SLVERR : RESP_OKAY);
  assign w_do_write  = w_hs & !w_beat_dec & !w_beat_slv & !rst;
  assign w_idx       = w_addr[IW+LNB-1:LNB];
  assign axi_bresp   = b_resp;

  // Write FSM state register
  always_ff @(posedge axi_aclk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // Write FSM next state: the beat counter, not wlast, decides where the burst ends
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (axi_awvalid)            w_state_nxt = W_DATA;
      W_DATA:  if (axi_wvalid && w_final)  w_state_nxt = W_RESP;
      W_RESP:  if (axi_bready)             w_state_nxt = W_IDLE;
      default:                             w_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs: channel readiness follows the state directly
  always_comb begin
    axi_awready = (w_state == W_IDLE);
    axi_wready  = (w_state == W_DATA);
    axi_bvalid  = (w_state == W_RESP);
  end

  // Write burst tracking: latch AW fields, step address, accumulate worst response
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr  <= axi_awaddr;
      w_len   <= axi_awlen;
      w_size  <= axi_awsize;
      w_burst <= axi_awburst;
      w_cnt   <= axi_awlen;
      w_err   <= burst_err(axi_awlen, axi_awsize, axi_awburst);
      b_resp  <= RESP_OKAY;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt  <= w_cnt - 8'd1;
      // a misplaced wlast poisons the rest of the burst as well
      if (w_last_bad)            w_err  <= 1'b1;
      if (w_beat_resp > b_resp)  b_resp <= w_beat_resp;
    end else if (b_hs) begin
      b_resp <= RESP_OKAY;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset
  always_ff @(posedge axi_aclk) begin
    if (w_do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= axi_wdata[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  rstate_t       r_state;
  rstate_t       r_state_nxt;
  logic [AW-1:0] r_addr;     // address of the beat currently on the R channel
  logic [7:0]    r_len;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic [7:0]    r_cnt;      // beats remaining after the current one
  logic          r_err;

  logic          ar_hs;
  logic          r_hs;
  logic          r_adv;
  logic [AW-1:0] r_load_addr;
  logic          r_load_err;
  logic [1:0]    r_load_resp;
  logic [DW-1:0] r_load_data;

  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = axi_rvalid & axi_rready;
  assign r_adv = r_hs & !axi_rlast;

  // Read FSM state register
  always_ff @(posedge axi_aclk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Read FSM next state: leave R_DATA once the last beat is accepted
  always_comb begin
    r_state_nxt = r_state;
    if (r_state == R_IDLE) begin
      if (axi_arvalid) r_state_nxt = R_DATA;
    end else begin
      if (axi_rready && axi_rlast) r_state_nxt = R_IDLE;
    end
  end

  // Read FSM outputs
  always_comb begin
    axi_arready = (r_state == R_IDLE);
    axi_rvalid  = (r_state == R_DATA);
  end

  // Next beat to present: beat 0 straight from AR, otherwise the stepped address.
  // RAM is read before the edge, so a write landing on the same edge is not seen.
  always_comb begin
    r_load_addr = ar_hs ? axi_araddr : next_addr(r_addr, r_len, r_size, r_burst);
    r_load_err  = ar_hs ? burst_err(axi_arlen, axi_arsize, axi_arburst) : r_err;
    if (!in_range(r_load_addr)) r_load_resp = RESP_DECERR;
    else if (r_load_err)        r_load_resp = RESP_SLVERR;
    else                        r_load_resp = RESP_OKAY;
    r_load_data = '0;
    if (r_load_resp == RESP_OKAY) r_load_data = mem[r_load_addr[IW+LNB-1:LNB]];
  end

  // R output register: loads on AR or on acceptance of a non-last beat, clears after last
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
      axi_rlast <= 1'b0;
    end else if (ar_hs || r_adv) begin
      r_addr    <= r_load_addr;
      axi_rdata <= r_load_data;
      axi_rresp <= r_load_resp;
      if (ar_hs) begin
        r_len     <= axi_arlen;
        r_size    <= axi_arsize;
        r_burst   <= axi_arburst;
        r_err     <= r_load_err;
        r_cnt     <= axi_arlen;
        axi_rlast <= (axi_arlen == 8'd0);
      end else begin
        r_cnt     <= r_cnt - 8'd1;
        axi_rlast <= (r_cnt == 8'd1);
      end
    end else if (r_hs) begin
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
      axi_rlast <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with queue-based B/R scoreboard.
// Stimulus tasks push expected responses; a negedge monitor pops on each handshake.
// rready can be toggled by a free-running driver to exercise R backpressure.
module tb_axi_mem_slave;

  logic        axi_aclk = 1'b0;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  axi_mem_slave dut (
    .axi_aclk(axi_aclk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t       r_q[$];
  logic [1:0]  b_q[$];
  logic [63:0] wd [16];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        rr_toggle   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last);
    rexp_t e;
    e.d = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  // Monitor: compare every B and R handshake against the scoreboard heads
  always @(negedge axi_aclk) begin
    if (!rst) begin
      if (axi_bvalid && axi_bready) begin
        if (b_q.size() == 0) check("b_unexpected", 64'(axi_bresp), 64'hFFFF);
        else                 check("bresp", 64'(axi_bresp), 64'(b_q.pop_front()));
      end
      if (axi_rvalid && axi_rready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", axi_rdata, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          rexp_t e;
          e = r_q.pop_front();
          check("rdata", axi_rdata, e.d);
          check("rresp", 64'(axi_rresp), 64'(e.resp));
          check("rlast", 64'(axi_rlast), 64'(e.last));
        end
      end
    end
  end

  // rready driver: held high, or alternating when rr_toggle is set
  initial begin
    axi_rready = 1'b1;
    forever begin
      @(posedge axi_aclk); #1;
      axi_rready = rr_toggle ? ~axi_rready : 1'b1;
    end
  end

  // Write burst from wd[]; wl_xor flips wlast per beat; nsend < len+1 abandons mid-burst.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [7:0] strb, input logic [15:0] wl_xor,
                             input int nsend, input logic [1:0] exp_resp);
    int  t;
    bit  full;
    full = (nsend == int'(len) + 1);
    if (full) b_q.push_back(exp_resp);
    @(posedge axi_aclk); #1;
    axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    t = 0;
    @(negedge axi_aclk);
    while (!axi_awready && t < 200) begin @(negedge axi_aclk); t++; end
    if (t >= 200) timed_out("aw_wait");
    @(posedge axi_aclk); #1;
    axi_awvalid = 1'b0;
    check("awready_after_aw", 64'(axi_awready), 64'd0);
    check("wready_after_aw", 64'(axi_wready), 64'd1);
    for (int i = 0; i < nsend; i++) begin
      axi_wdata  = wd[i];
      axi_wstrb  = strb;
      axi_wlast  = (i == int'(len)) ^ wl_xor[i];
      axi_wvalid = 1'b1;
      t = 0;
      @(negedge axi_aclk);
      while (!axi_wready && t < 200) begin @(negedge axi_aclk); t++; end
      if (t >= 200) timed_out("w_wait");
      @(posedge axi_aclk); #1;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    if (full) begin
      check("wready_after_last", 64'(axi_wready), 64'd0);
      check("bvalid_after_last", 64'(axi_bvalid), 64'd1);
      t = 0;
      @(negedge axi_aclk);
      while (!axi_awready && t < 200) begin @(negedge axi_aclk); t++; end
      if (t >= 200) timed_out("b_wait");
    end
  endtask

  // Read burst; expected beats must already be on r_q.
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(posedge axi_aclk); #1;
    axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    t = 0;
    @(negedge axi_aclk);
    while (!axi_arready && t < 200) begin @(negedge axi_aclk); t++; end
    if (t >= 200) timed_out("ar_wait");
    @(posedge axi_aclk); #1;
    axi_arvalid = 1'b0;
    check("rvalid_after_ar", 64'(axi_rvalid), 64'd1);
    check("arready_after_ar", 64'(axi_arready), 64'd0);
    t = 0;
    @(negedge axi_aclk);
    while (!axi_arready && t < 400) begin @(negedge axi_aclk); t++; end
    if (t >= 400) timed_out("r_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b1;
    axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0; axi_arvalid = 1'b0;

    repeat (3) @(posedge axi_aclk);
    #1;
    check("rst_awready", 64'(axi_awready), 64'd1);
    check("rst_wready",  64'(axi_wready),  64'd0);
    check("rst_bvalid",  64'(axi_bvalid),  64'd0);
    check("rst_bresp",   64'(axi_bresp),   64'd0);
    check("rst_arready", 64'(axi_arready), 64'd1);
    check("rst_rvalid",  64'(axi_rvalid),  64'd0);
    check("rst_rdata",   axi_rdata,        64'd0);
    check("rst_rresp",   64'(axi_rresp),   64'd0);
    check("rst_rlast",   64'(axi_rlast),   64'd0);
    rst = 1'b0;

    // INCR write 0x10 len 3 -> words 2..5 = 1..4, then read back
    for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
    write_burst(32'h10, 8'd3, 3'd3, 2'b01, 8'hFF, 16'h0, 4, 2'b00);
    for (int i = 0; i < 4; i++) push_r(64'(i + 1), 2'b00, i == 3);
    read_burst(32'h10, 8'd3, 3'd3, 2'b01);

    // words 0,1 = A0,A1; WRAP read from 0x18 visits words 3,0,1,2
    wd[0] = 64'hA0; wd[1] = 64'hA1;
    write_burst(32'h0, 8'd1, 3'd3, 2'b01, 8'hFF, 16'h0, 2, 2'b00);
    push_r(64'd2, 2'b00, 1'b0);
    push_r(64'hA0, 2'b00, 1'b0);
    push_r(64'hA1, 2'b00, 1'b0);
    push_r(64'd1, 2'b00, 1'b1);
    read_burst(32'h18, 8'd3, 3'd3, 2'b10);

    // misplaced wlast: SLVERR and no RAM update
    wd[0] = 64'h55; wd[1] = 64'h66;
    write_burst(32'h40, 8'd1, 3'd3, 2'b01, 8'hFF, 16'h0, 2, 2'b00);
    wd[0] = 64'h77; wd[1] = 64'h88;
    write_burst(32'h40, 8'd1, 3'd3, 2'b01, 8'hFF, 16'h3, 2, 2'b10);
    push_r(64'h55, 2'b00, 1'b0);
    push_r(64'h66, 2'b00, 1'b1);
    read_burst(32'h40, 8'd1, 3'd3, 2'b01);

    // top of RAM: second beat decodes out of range
    wd[0] = 64'h1234; wd[1] = 64'h5678;
    write_burst(32'h7F8, 8'd1, 3'd3, 2'b01, 8'hFF, 16'h0, 2, 2'b11);
    push_r(64'h1234, 2'b00, 1'b0);
    push_r(64'h0, 2'b11, 1'b1);
    read_burst(32'h7F8, 8'd1, 3'd3, 2'b01);

    // partial strobe onto a zeroed word, single-beat read
    wd[0] = 64'h0;
    write_burst(32'h200, 8'd0, 3'd3, 2'b01, 8'hFF, 16'h0, 1, 2'b00);
    wd[0] = 64'hAABBCCDD_11223344;
    write_burst(32'h200, 8'd0, 3'd3, 2'b01, 8'h0F, 16'h0, 1, 2'b00);
    push_r(64'h00000000_11223344, 2'b00, 1'b1);
    read_burst(32'h200, 8'd0, 3'd3, 2'b01);

    // FIXED burst rewrites one word; reserved burst type reads as SLVERR with zero data
    wd[0] = 64'hF1; wd[1] = 64'hF2;
    write_burst(32'h380, 8'd1, 3'd3, 2'b00, 8'hFF, 16'h0, 2, 2'b00);
    push_r(64'hF2, 2'b00, 1'b1);
    read_burst(32'h380, 8'd0, 3'd3, 2'b01);
    push_r(64'h0, 2'b10, 1'b0);
    push_r(64'h0, 2'b10, 1'b1);
    read_burst(32'h10, 8'd1, 3'd3, 2'b11);

    // concurrent write and read with rready toggling
    for (int i = 0; i < 4; i++) wd[i] = 64'(8'h31 + i);
    for (int i = 0; i < 4; i++) push_r(64'(i + 1), 2'b00, i == 3);
    rr_toggle = 1'b1;
    fork
      write_burst(32'h300, 8'd3, 3'd3, 2'b01, 8'hFF, 16'h0, 4, 2'b00);
      read_burst(32'h10, 8'd3, 3'd3, 2'b01);
    join
    rr_toggle = 1'b0;
    for (int i = 0; i < 4; i++) push_r(64'(8'h31 + i), 2'b00, i == 3);
    read_burst(32'h300, 8'd3, 3'd3, 2'b01);

    // reset in the middle of a write burst; two beats already stored
    for (int i = 0; i < 4; i++) wd[i] = 64'(8'hC1 + i);
    write_burst(32'h100, 8'd3, 3'd3, 2'b01, 8'hFF, 16'h0, 2, 2'b00);
    rst = 1'b1;
    @(posedge axi_aclk); #1;
    check("midrst_awready", 64'(axi_awready), 64'd1);
    check("midrst_wready",  64'(axi_wready),  64'd0);
    check("midrst_bvalid",  64'(axi_bvalid),  64'd0);
    rst = 1'b0;
    push_r(64'hC1, 2'b00, 1'b0);
    push_r(64'hC2, 2'b00, 1'b1);
    read_burst(32'h100, 8'd1, 3'd3, 2'b01);

    repeat (4) @(posedge axi_aclk);
    #1;
    check("b_queue_drained", 64'(b_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
